// File: rtl/avs_uart_pkg.sv
// Shared register map, status/error bit positions and transfer-state encoding
// for the Avalon-MM UART responder.
package avs_uart_pkg;

  localparam logic [4:0] RX_BASE     = 5'h00;
  localparam logic [4:0] TX_BASE     = 5'h04;
  localparam logic [4:0] STATUS_BASE = 5'h08;

  localparam int TX_OK_BIT = 6;
  localparam int RX_OK_BIT = 7;

  localparam int ERR_RX_UNDERRUN = 0;
  localparam int ERR_TX_OVERFLOW = 1;
  localparam int ERR_PROTO       = 2;
  localparam int ERR_W           = 3;

  typedef enum logic [1:0] {
    XFER_IDLE  = 2'd0,
    XFER_STALL = 2'd1,
    XFER_DONE  = 2'd2
  } xfer_state_t;

  function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                              input logic [ERR_W-1:0] err);
    logic [31:0] w;
    w = '0;
    w[RX_OK_BIT] = rx_ok;
    w[TX_OK_BIT] = tx_ok;
    w[ERR_W-1:0] = err;
    return w;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a full FIFO refuses pushes even
// when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/avs_uart_responder.sv
// Avalon-MM slave emulating a polled RS232 UART: RX/TX byte FIFOs behind a
// three-register map, with programmable waitrequest stalling per transfer.
module avs_uart_responder
  import avs_uart_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int TX_DEPTH    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             avm_clk,
  input  logic             avm_rst,
  input  logic [4:0]       avm_address,
  input  logic             avm_read,
  output logic [31:0]      avm_readdata,
  input  logic             avm_write,
  input  logic [31:0]      avm_writedata,
  output logic             avm_waitrequest,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [ERR_W-1:0] o_err
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  xfer_state_t      state_q;
  xfer_state_t      state_d;
  logic [3:0]       wait_cnt_q;
  logic [3:0]       wait_cnt_d;
  logic             req;
  logic             done_window;
  logic             complete;
  logic             rd_done;
  logic             wr_done;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_pop;
  logic [7:0]       rx_head;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_push;
  logic [ERR_W-1:0] err_q;
  logic             unused_wdata;

  assign req = avm_read || avm_write;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q    <= XFER_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // done_window marks the single cycle in which waitrequest is low.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    done_window = 1'b0;
    case (state_q)
      XFER_IDLE: begin
        wait_cnt_d = '0;
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done_window = 1'b1;
          end else begin
            state_d    = XFER_STALL;
            wait_cnt_d = 4'd1;
          end
        end
      end
      XFER_STALL: begin
        if (!req) begin
          state_d    = XFER_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d = XFER_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      XFER_DONE: begin
        done_window = 1'b1;
        state_d     = XFER_IDLE;
        wait_cnt_d  = '0;
      end
      default: begin
        state_d    = XFER_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign avm_waitrequest = avm_rst || !done_window;
  assign complete        = done_window && req && !avm_rst;
  assign rd_done         = complete && avm_read;
  assign wr_done         = complete && avm_write && !avm_read;
  assign rx_pop          = rd_done && (avm_address == RX_BASE);
  assign tx_push         = wr_done && (avm_address == TX_BASE);

  // Read data comes only from registered state; no bypass of same-cycle pushes.
  always_comb begin
    avm_readdata = '0;
    if (rd_done) begin
      case (avm_address)
        RX_BASE:     avm_readdata = rx_empty ? 32'h0 : {24'h0, rx_head};
        STATUS_BASE: avm_readdata = status_word(!rx_empty, !tx_full, err_q);
        default:     avm_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      err_q <= '0;
    end else begin
      if (rx_pop && rx_empty) err_q[ERR_RX_UNDERRUN] <= 1'b1;
      if (tx_push && tx_full) err_q[ERR_TX_OVERFLOW] <= 1'b1;
      if (rd_done && avm_write) err_q[ERR_PROTO] <= 1'b1;
    end
  end

  assign o_err        = err_q;
  assign o_rx_ready   = !rx_full;
  assign o_tx_valid   = !tx_empty;
  assign unused_wdata = &{1'b0, avm_writedata[31:8]};

  byte_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk       (avm_clk),
    .rst       (avm_rst),
    .push      (i_rx_valid),
    .push_data (i_rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  byte_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (avm_clk),
    .rst       (avm_rst),
    .push      (tx_push),
    .push_data (avm_writedata[7:0]),
    .pop       (i_tx_ready),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (o_tx_data)
  );

endmodule

// File: tb/tb_avs_uart_responder.sv
// Bench for avs_uart_responder: a stalling instance (WAIT_CYCLES=1) and a
// full-rate instance (WAIT_CYCLES=0) checked against a queue-based model.
module tb_avs_uart_responder;
  import avs_uart_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  a_address;
  logic        a_read;
  logic [31:0] a_readdata;
  logic        a_write;
  logic [31:0] a_writedata;
  logic        a_waitrequest;
  logic [7:0]  a_rx_data;
  logic        a_rx_valid;
  logic        a_rx_ready;
  logic [7:0]  a_tx_data;
  logic        a_tx_valid;
  logic        a_tx_ready;
  logic [2:0]  a_err;

  logic [4:0]  b_address;
  logic        b_read;
  logic [31:0] b_readdata;
  logic        b_write;
  logic [31:0] b_writedata;
  logic        b_waitrequest;
  logic [7:0]  b_rx_data;
  logic        b_rx_valid;
  logic        b_rx_ready;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid;
  logic        b_tx_ready;
  logic [2:0]  b_err;

  avs_uart_responder #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .WAIT_CYCLES(1)) dut (
    .avm_clk(clk), .avm_rst(rst), .avm_address(a_address), .avm_read(a_read),
    .avm_readdata(a_readdata), .avm_write(a_write), .avm_writedata(a_writedata),
    .avm_waitrequest(a_waitrequest), .i_rx_data(a_rx_data), .i_rx_valid(a_rx_valid),
    .o_rx_ready(a_rx_ready), .o_tx_data(a_tx_data), .o_tx_valid(a_tx_valid),
    .i_tx_ready(a_tx_ready), .o_err(a_err)
  );

  avs_uart_responder #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_fast (
    .avm_clk(clk), .avm_rst(rst), .avm_address(b_address), .avm_read(b_read),
    .avm_readdata(b_readdata), .avm_write(b_write), .avm_writedata(b_writedata),
    .avm_waitrequest(b_waitrequest), .i_rx_data(b_rx_data), .i_rx_valid(b_rx_valid),
    .o_rx_ready(b_rx_ready), .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid),
    .i_tx_ready(b_tx_ready), .o_err(b_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents as queues plus sticky error bits.
  logic [7:0] m_rx[$];
  logic [7:0] exp_q[$];
  logic [2:0] m_err;
  logic [7:0] sink_q[$];

  always @(negedge clk) begin
    if (!rst && a_tx_valid && a_tx_ready) sink_q.push_back(a_tx_data);
  end

  function automatic logic [31:0] model_xfer(input bit rd, input bit wr,
                                             input logic [4:0] addr, input logic [7:0] wd);
    logic [31:0] r;
    r = '0;
    if (rd) begin
      if (addr == 5'h08) begin
        r[7]   = (m_rx.size() != 0);
        r[6]   = (exp_q.size() < DEPTH);
        r[2:0] = m_err;
      end else if (addr == 5'h00) begin
        if (m_rx.size() == 0) m_err[0] = 1'b1;
        else r[7:0] = m_rx.pop_front();
      end
      if (wr) m_err[2] = 1'b1;
    end else if (wr && addr == 5'h04) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(wd);
      else m_err[1] = 1'b1;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_read = 1'b0; a_write = 1'b0; a_rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_rx.delete(); exp_q.delete(); sink_q.delete(); m_err = 3'b000;
  endtask

  // Called at posedge+1; returns readdata of the completion cycle and the
  // number of stalled cycles observed before it.
  task automatic bus_op(input bit rd, input bit wr, input logic [4:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdat, output int waits);
    a_read = rd; a_write = wr; a_address = addr; a_writedata = wd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!a_waitrequest || waits > 20) break;
      waits++;
    end
    rdat = a_readdata;
    @(posedge clk); #1;
    a_read = 1'b0; a_write = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    logic exp_rdy;
    a_rx_valid = 1'b1; a_rx_data = d;
    @(negedge clk);
    exp_rdy = (m_rx.size() < DEPTH);
    checks++;
    if (a_rx_ready !== exp_rdy) begin
      failures++; $display("FAIL rx_ready: got %b expected %b", a_rx_ready, exp_rdy);
    end
    if (exp_rdy) m_rx.push_back(d);
    @(posedge clk); #1;
    a_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 6;
    if (a_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait: got %b expected 1", a_waitrequest); end
    if (a_readdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", a_readdata); end
    if (a_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_txv: got %b expected 0", a_tx_valid); end
    if (a_rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rxr: got %b expected 1", a_rx_ready); end
    if (a_err !== 3'b000) begin failures++; $display("FAIL reset_err: got %b expected 000", a_err); end
    if (b_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait_fast: got %b expected 1", b_waitrequest); end
    @(posedge clk); #1;
  endtask

  task automatic test_status_wait();
    logic [2:0]  seq;
    logic [31:0] rd;
    logic [31:0] exp;
    rd = '0;
    a_read = 1'b1; a_address = STATUS_BASE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seq[i] = a_waitrequest;
      if (i == 2) rd = a_readdata;
    end
    @(posedge clk); #1;
    a_read = 1'b0;
    exp = model_xfer(1'b1, 1'b0, STATUS_BASE, 8'h00);
    checks += 2;
    if (seq !== 3'b011) begin failures++; $display("FAIL status_wait_seq: got %b expected 011", seq); end
    if (rd !== exp) begin failures++; $display("FAIL status_first: got %h expected %h", rd, exp); end
  endtask

  task automatic test_rx_stream();
    logic [31:0] rd;
    logic [31:0] exp;
    int waits;
    logic [4:0] addrs[4];
    addrs[0] = STATUS_BASE; addrs[1] = RX_BASE; addrs[2] = RX_BASE; addrs[3] = STATUS_BASE;
    rx_push(8'hA5);
    rx_push(8'h3C);
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b1, 1'b0, addrs[i], 32'h0, rd, waits);
      exp = model_xfer(1'b1, 1'b0, addrs[i], 8'h00);
      checks += 2;
      if (rd !== exp) begin failures++; $display("FAIL rx_stream_%0d: got %h expected %h", i, rd, exp); end
      if (waits !== 2) begin failures++; $display("FAIL rx_stream_waits: got %0d expected 2", waits); end
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd;
    logic [31:0] exp;
    int waits;
    int budget;
    do_reset();
    a_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_op(1'b0, 1'b1, TX_BASE, 32'h11 + i, rd, waits);
      void'(model_xfer(1'b0, 1'b1, TX_BASE, 8'(8'h11 + i)));
      if (i == 3) begin
        bus_op(1'b1, 1'b0, STATUS_BASE, 32'h0, rd, waits);
        exp = model_xfer(1'b1, 1'b0, STATUS_BASE, 8'h00);
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL tx_full_status: got %h expected %h", rd, exp); end
      end
    end
    a_tx_ready = 1'b1;
    budget = 0;
    while (sink_q.size() < exp_q.size() && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    @(posedge clk); #1;
    a_tx_ready = 1'b0;
    checks++;
    if (sink_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL tx_drain_count: got %0d expected %0d", sink_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < sink_q.size(); i++) begin
      checks++;
      if (sink_q[i] !== exp_q[i]) begin failures++; $display("FAIL tx_order_%0d: got %h expected %h", i, sink_q[i], exp_q[i]); end
    end
    exp_q.delete(); sink_q.delete();
    checks++;
    if (a_err !== m_err) begin failures++; $display("FAIL tx_ovf_err: got %b expected %b", a_err, m_err); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic [31:0] exp;
    int waits;
    do_reset();
    bus_op(1'b1, 1'b0, RX_BASE, 32'h0, rd, waits);
    exp = model_xfer(1'b1, 1'b0, RX_BASE, 8'h00);
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL underrun_rdata: got %h expected %h", rd, exp); end
    bus_op(1'b1, 1'b1, TX_BASE, 32'h77, rd, waits);
    exp = model_xfer(1'b1, 1'b1, TX_BASE, 8'h77);
    checks += 3;
    if (rd !== exp) begin failures++; $display("FAIL proto_rdata: got %h expected %h", rd, exp); end
    if (a_tx_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL proto_write_ignored: got %b", a_tx_valid); end
    if (a_err !== m_err) begin failures++; $display("FAIL err_sticky: got %b expected %b", a_err, m_err); end
    // Reset while the transfer is stalled, then drop the request mid-stall.
    a_read = 1'b1; a_address = STATUS_BASE;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_rx.delete(); exp_q.delete(); m_err = 3'b000;
    @(negedge clk);
    checks += 4;
    if (a_waitrequest !== 1'b1) begin failures++; $display("FAIL midrst_wait: got %b expected 1", a_waitrequest); end
    if (a_err !== 3'b000) begin failures++; $display("FAIL midrst_err: got %b expected 000", a_err); end
    if (a_tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_txv: got %b expected 0", a_tx_valid); end
    if (a_rx_ready !== 1'b1) begin failures++; $display("FAIL midrst_rxr: got %b expected 1", a_rx_ready); end
    @(posedge clk); #1;
    a_read = 1'b0;
    @(posedge clk); #1;
    bus_op(1'b1, 1'b0, STATUS_BASE, 32'h0, rd, waits);
    exp = model_xfer(1'b1, 1'b0, STATUS_BASE, 8'h00);
    checks += 2;
    if (rd !== exp) begin failures++; $display("FAIL after_drop_status: got %h expected %h", rd, exp); end
    if (waits !== 2) begin failures++; $display("FAIL after_drop_waits: got %0d expected 2", waits); end
  endtask

  task automatic test_rx_full_pushpop();
    logic [31:0] rd;
    logic [31:0] exp;
    int waits;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) rx_push(8'($urandom));
    a_rx_valid = 1'b1; a_rx_data = 8'hEE;
    a_read = 1'b1; a_address = RX_BASE;
    rd = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (a_rx_ready !== 1'b0) begin failures++; $display("FAIL full_rx_ready_%0d: got %b expected 0", i, a_rx_ready); end
      if (!a_waitrequest) begin rd = a_readdata; break; end
    end
    @(posedge clk); #1;
    a_read = 1'b0; a_rx_valid = 1'b0;
    exp = model_xfer(1'b1, 1'b0, RX_BASE, 8'h00);
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL full_pop_rdata: got %h expected %h", rd, exp); end
    @(negedge clk);
    checks++;
    if (a_rx_ready !== (m_rx.size() < DEPTH)) begin failures++; $display("FAIL after_pop_ready: got %b", a_rx_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus_op(1'b1, 1'b0, (i == 3) ? STATUS_BASE : RX_BASE, 32'h0, rd, waits);
      exp = model_xfer(1'b1, 1'b0, (i == 3) ? STATUS_BASE : RX_BASE, 8'h00);
      checks++;
      if (rd !== exp) begin failures++; $display("FAIL full_remaining_%0d: got %h expected %h", i, rd, exp); end
    end
  endtask

  task automatic test_full_rate();
    logic [7:0] bytes[32];
    logic [4:0] nxt;
    int sent;
    int recv;
    int cyc;
    sent = 0; recv = 0; cyc = 0;
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
    b_read = 1'b1; b_address = STATUS_BASE; b_rx_valid = 1'b1; b_rx_data = bytes[0];
    while (recv < 32 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (b_waitrequest !== 1'b0) begin failures++; $display("FAIL fast_wait: got %b expected 0 cycle %0d", b_waitrequest, cyc); end
      if (b_address == STATUS_BASE) begin
        checks++;
        if (b_readdata[31:8] !== 24'h0 || b_readdata[6:0] !== 7'h40) begin
          failures++; $display("FAIL fast_status: got %h expected 40/c0", b_readdata);
        end
        nxt = b_readdata[7] ? RX_BASE : STATUS_BASE;
      end else begin
        checks++;
        if (b_readdata !== {24'h0, bytes[recv]}) begin
          failures++; $display("FAIL fast_byte_%0d: got %h expected %h", recv, b_readdata, bytes[recv]);
        end
        recv++;
        nxt = STATUS_BASE;
      end
      if (b_rx_valid && b_rx_ready) sent++;
      @(posedge clk); #1;
      b_address = nxt;
      b_rx_valid = (sent < 32);
      if (sent < 32) b_rx_data = bytes[sent];
    end
    b_read = 1'b0; b_rx_valid = 1'b0;
    checks += 2;
    if (recv !== 32) begin failures++; $display("FAIL fast_count: got %0d expected 32", recv); end
    if (b_err !== 3'b000) begin failures++; $display("FAIL fast_err: got %b expected 000", b_err); end
  endtask

  task automatic test_random_ops();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [4:0]  addr;
    logic [7:0]  d;
    int waits;
    int op;
    int budget;
    do_reset();
    a_tx_ready = 1'b0;
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 5);
      d = 8'($urandom);
      case (op)
        0: rx_push(d);
        1, 2, 4: begin
          if (op == 1) addr = RX_BASE;
          else if (op == 2) addr = STATUS_BASE;
          else begin
            addr = 5'($urandom_range(0, 31));
            if (addr == RX_BASE || addr == TX_BASE || addr == STATUS_BASE) addr = 5'h0C;
          end
          bus_op(1'b1, 1'b0, addr, 32'h0, rd, waits);
          exp = model_xfer(1'b1, 1'b0, addr, 8'h00);
          checks += 2;
          if (rd !== exp) begin failures++; $display("FAIL rand_read_%0d addr %h: got %h expected %h", n, addr, rd, exp); end
          if (waits !== 2) begin failures++; $display("FAIL rand_waits_%0d: got %0d expected 2", n, waits); end
        end
        3: begin
          addr = ($urandom_range(0, 3) == 0) ? 5'h14 : TX_BASE;
          bus_op(1'b0, 1'b1, addr, {24'hFFFFFF, d}, rd, waits);
          void'(model_xfer(1'b0, 1'b1, addr, d));
        end
        default: begin
          addr = ($urandom_range(0, 1) == 0) ? RX_BASE : STATUS_BASE;
          bus_op(1'b1, 1'b1, addr, {24'h0, d}, rd, waits);
          exp = model_xfer(1'b1, 1'b1, addr, d);
          checks++;
          if (rd !== exp) begin failures++; $display("FAIL rand_rdwr_%0d: got %h expected %h", n, rd, exp); end
        end
      endcase
    end
    a_tx_ready = 1'b1;
    budget = 0;
    while (sink_q.size() < exp_q.size() && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    @(posedge clk); #1;
    a_tx_ready = 1'b0;
    checks += 2;
    if (sink_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL rand_drain_count: got %0d expected %0d", sink_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < sink_q.size(); i++) begin
      checks++;
      if (sink_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_tx_%0d: got %h expected %h", i, sink_q[i], exp_q[i]); end
    end
    if (a_err !== m_err) begin failures++; $display("FAIL rand_err: got %b expected %b", a_err, m_err); end
    exp_q.delete(); sink_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    a_address = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0;
    a_rx_data = '0; a_rx_valid = 1'b0; a_tx_ready = 1'b0;
    b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
    b_rx_data = '0; b_rx_valid = 1'b0; b_tx_ready = 1'b1;
    m_err = 3'b000;
    test_reset();
    test_status_wait();
    test_rx_stream();
    test_tx_overflow();
    test_errors();
    test_rx_full_pushpop();
    test_full_rate();
    test_random_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
